// File: rtl/lcd_text_renderer.sv
// rtl/lcd_text_renderer.sv - 8x8 character-cell text renderer for an RGB888 LCD pixel stream
//
// Purpose:
//   Turns a raster pixel stream (de/hs/vs + x/y) into rendered text pixels.
//   The pixel position selects an 8x8 character cell. An external character
//   generator supplies the code for that cell. An external synchronous font
//   ROM supplies the glyph line. Each glyph bit becomes FG_COLOR or BG_COLOR.
//   One pixel is accepted per clock with no stalls. Every input cycle N
//   appears at the outputs during cycle N+4.
//
// Ports:
//   clock         sole clock, rising edge
//   reset         synchronous, active-high; clears every pipeline register
//   in_de         data enable, pixel (in_x,in_y) is visible
//   in_hs/in_vs   sync strobes, delayed by 4 cycles to out_hs/out_vs
//   in_x/in_y     pixel column 0..799 / row 0..479
//   column/row    character cell to the character generator (valid N+1)
//   character     character code from the generator (combinational from column/row)
//   font_address  {character, glyph line} to the font ROM (valid N+2)
//   font_data     glyph line from the ROM (valid N+3), bit 7 = leftmost pixel
//   out_de/hs/vs  delayed de/hs/vs (valid N+4)
//   out_rgb       rendered pixel colour (valid N+4), black while out_de = 0

module lcd_text_renderer #(
    parameter logic [23:0] FG_COLOR = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR = 24'h000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_de,
    input  logic        in_hs,
    input  logic        in_vs,
    input  logic [9:0]  in_x,
    input  logic [9:0]  in_y,
    output logic [6:0]  column,
    output logic [5:0]  row,
    input  logic [6:0]  character,
    output logic [9:0]  font_address,
    input  logic [7:0]  font_data,
    output logic        out_de,
    output logic        out_hs,
    output logic        out_vs,
    output logic [23:0] out_rgb
);

    // Stage 1 (valid N+1): cell address and the in-cell pixel offsets
    logic [6:0]  r_column;
    logic [5:0]  r_row;
    logic [2:0]  r_y_sub1;

    // Pixel-within-glyph column, carried until the glyph line arrives in N+3
    logic [2:0]  r_x_sub1;
    logic [2:0]  r_x_sub2;
    logic [2:0]  r_x_sub3;

    // Stage 2 (valid N+2): font ROM address
    logic [9:0]  r_font_address;

    // Timing strobes. Bit k holds the cycle-N value during cycle N+k+1.
    logic [3:0]  r_de_pipe;
    logic [3:0]  r_hs_pipe;
    logic [3:0]  r_vs_pipe;

    // Stage 4 (valid N+4): rendered colour
    logic [23:0] r_rgb;

    logic        w_pixel_on;
    logic        w_unused_y_msb;

    // Rows 480..511 never occur, so the top row bit is not part of the cell address
    assign w_unused_y_msb = in_y[9];

    // Bit 7 of the glyph line is the leftmost pixel of the cell
    assign w_pixel_on = font_data[3'd7 - r_x_sub3];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_column       <= '0;
            r_row          <= '0;
            r_y_sub1       <= '0;
            r_x_sub1       <= '0;
            r_x_sub2       <= '0;
            r_x_sub3       <= '0;
            r_font_address <= '0;
            r_de_pipe      <= '0;
            r_hs_pipe      <= '0;
            r_vs_pipe      <= '0;
            r_rgb          <= '0;
        end else begin
            // Addresses update during blanking as well. They are unused then,
            // but they stay deterministic.
            r_column       <= in_x[9:3];
            r_row          <= in_y[8:3];
            r_y_sub1       <= in_y[2:0];
            r_x_sub1       <= in_x[2:0];
            r_x_sub2       <= r_x_sub1;
            r_x_sub3       <= r_x_sub2;
            r_font_address <= {character, r_y_sub1};
            r_de_pipe      <= {r_de_pipe[2:0], in_de};
            r_hs_pipe      <= {r_hs_pipe[2:0], in_hs};
            r_vs_pipe      <= {r_vs_pipe[2:0], in_vs};
            // r_de_pipe[2] is the cycle-N de, seen during N+3 alongside font_data
            if (r_de_pipe[2]) begin
                r_rgb <= w_pixel_on ? FG_COLOR : BG_COLOR;
            end else begin
                r_rgb <= 24'h000000;
            end
        end
    end

    assign column       = r_column;
    assign row          = r_row;
    assign font_address = r_font_address;
    assign out_de       = r_de_pipe[3];
    assign out_hs       = r_hs_pipe[3];
    assign out_vs       = r_vs_pipe[3];
    assign out_rgb      = r_rgb;

endmodule

// File: tb/tb_lcd_text_renderer.sv
// tb/tb_lcd_text_renderer.sv - directed self-checking bench for lcd_text_renderer

module tb_lcd_text_renderer;

    localparam logic [23:0] FG = 24'hFFFFFF;
    localparam logic [23:0] BG = 24'h000000;
    localparam int          HN = 256;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_de = 1'b0;
    logic        in_hs = 1'b0;
    logic        in_vs = 1'b0;
    logic [9:0]  in_x  = '0;
    logic [9:0]  in_y  = '0;
    logic [6:0]  column;
    logic [5:0]  row;
    logic [6:0]  character;
    logic [9:0]  font_address;
    logic [7:0]  font_data = 8'h00;
    logic        out_de;
    logic        out_hs;
    logic        out_vs;
    logic [23:0] out_rgb;

    always #5 clock = ~clock;

    lcd_text_renderer #(.FG_COLOR(FG), .BG_COLOR(BG)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_de        (in_de),
        .in_hs        (in_hs),
        .in_vs        (in_vs),
        .in_x         (in_x),
        .in_y         (in_y),
        .column       (column),
        .row          (row),
        .character    (character),
        .font_address (font_address),
        .font_data    (font_data),
        .out_de       (out_de),
        .out_hs       (out_hs),
        .out_vs       (out_vs),
        .out_rgb      (out_rgb)
    );

    // Character generator: a distinct code per cell, 'A' at cell (1,2)
    function automatic logic [6:0] char_of(input logic [6:0] c, input logic [5:0] r);
        if (c == 7'd1 && r == 6'd2) return 7'h41;
        return c ^ {r, 1'b0};
    endfunction

    assign character = char_of(column, row);

    // Synchronous font ROM, one cycle latency
    logic [7:0] rom [0:1023];
    always @(posedge clock) font_data <= rom[font_address];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic        h_rst [HN];
    logic        h_de  [HN];
    logic        h_hs  [HN];
    logic        h_vs  [HN];
    logic [9:0]  h_x   [HN];
    logic [9:0]  h_y   [HN];
    logic        o_de  [HN];
    logic        o_hs  [HN];
    logic        o_vs  [HN];
    logic [23:0] o_rgb [HN];
    logic [6:0]  o_col [HN];
    logic [5:0]  o_row [HN];
    logic [9:0]  o_fa  [HN];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    endtask

    task automatic fill_rom(input logic [7:0] v);
        for (int a = 0; a < 1024; a++) rom[a] = v;
    endtask

    function automatic logic [9:0] exp_fa(input int j);
        return {char_of(h_x[j][9:3], h_y[j][8:3]), h_y[j][2:0]};
    endfunction

    function automatic logic rst_between(input int lo, input int hi);
        for (int j = lo; j <= hi; j++) if (j >= 0 && h_rst[j]) return 1'b1;
        return 1'b0;
    endfunction

    // One pixel cycle: drive, sample mid-cycle, check against the reference timeline
    task automatic run_cycle(input logic rst, input logic de, input logic hs, input logic vs,
                             input logic [9:0] x, input logic [9:0] y);
        logic [7:0]  line;
        logic [2:0]  xs;
        logic [23:0] e_rgb;
        reset = rst; in_de = de; in_hs = hs; in_vs = vs; in_x = x; in_y = y;
        h_rst[cyc] = rst; h_de[cyc] = de; h_hs[cyc] = hs; h_vs[cyc] = vs;
        h_x[cyc] = x; h_y[cyc] = y;
        @(negedge clock);
        o_de[cyc] = out_de; o_hs[cyc] = out_hs; o_vs[cyc] = out_vs; o_rgb[cyc] = out_rgb;
        o_col[cyc] = column; o_row[cyc] = row; o_fa[cyc] = font_address;
        if (cyc >= 1) begin
            check("column", 32'(column), h_rst[cyc-1] ? 32'd0 : 32'(h_x[cyc-1][9:3]));
            check("row",    32'(row),    h_rst[cyc-1] ? 32'd0 : 32'(h_y[cyc-1][8:3]));
        end
        if (cyc >= 2)
            check("font_address", 32'(font_address), rst_between(cyc-2, cyc-1) ? 32'd0 : 32'(exp_fa(cyc-2)));
        if (cyc >= 1 && rst_between(cyc-4, cyc-1)) begin
            check("out_de_rst",  32'(out_de),  32'd0);
            check("out_hs_rst",  32'(out_hs),  32'd0);
            check("out_vs_rst",  32'(out_vs),  32'd0);
            check("out_rgb_rst", 32'(out_rgb), 32'd0);
        end else if (cyc >= 4) begin
            line  = rom[exp_fa(cyc-4)];
            xs    = h_x[cyc-4][2:0];
            e_rgb = !h_de[cyc-4] ? 24'h000000 : (line[3'd7 - xs] ? FG : BG);
            check("out_de",  32'(out_de),  32'(h_de[cyc-4]));
            check("out_hs",  32'(out_hs),  32'(h_hs[cyc-4]));
            check("out_vs",  32'(out_vs),  32'(h_vs[cyc-4]));
            check("out_rgb", 32'(out_rgb), 32'(e_rgb));
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    endtask

    int n31, n32, n32b, nb, ns, nr, k;

    initial begin
        fill_rom(8'h00);
        @(posedge clock);
        #1;

        // Reset for two cycles with de/hs high
        run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 10'd13, 10'd21);
        run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 10'd13, 10'd21);
        idle(6);
        check("rst_de1",  32'(o_de[1]),  32'd0);
        check("rst_hs1",  32'(o_hs[1]),  32'd0);
        check("rst_rgb1", 32'(o_rgb[1]), 32'd0);
        check("rst_col2", 32'(o_col[2]), 32'd0);
        check("rst_fa2",  32'(o_fa[2]),  32'd0);

        // Single pixel at origin, glyph line 0x80
        fill_rom(8'h80);
        n31 = cyc;
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
        idle(6);
        check("lat_de",   32'(o_de[n31+4]),  32'd1);
        check("lat_rgb",  32'(o_rgb[n31+4]), 32'hFFFFFF);
        check("lat_de3",  32'(o_de[n31+3]),  32'd0);

        // Addressing: (13,21) -> cell (1,2), 'A', address 0x20D, bit 2
        fill_rom(8'h00);
        rom[10'h20D] = 8'h04;
        n32 = cyc;
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 10'd13, 10'd21);
        idle(6);
        check("addr_col", 32'(o_col[n32+1]), 32'd1);
        check("addr_row", 32'(o_row[n32+1]), 32'd2);
        check("addr_fa",  32'(o_fa[n32+2]),  32'h20D);
        check("addr_fg",  32'(o_rgb[n32+4]), 32'hFFFFFF);
        rom[10'h20D] = 8'hFB;
        n32b = cyc;
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 10'd13, 10'd21);
        idle(6);
        check("addr_bg",  32'(o_rgb[n32b+4]), 32'h000000);
        check("addr_bde", 32'(o_de[n32b+4]),  32'd1);

        // Blanking with ROM all ones; hs then vs pulses
        fill_rom(8'hFF);
        nb = cyc;
        run_cycle(1'b0, 1'b0, 1'b1, 1'b0, 10'd5, 10'd5);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 10'd6, 10'd5);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b1, 10'd7, 10'd5);
        idle(7);
        check("blank_rgb", 32'(o_rgb[nb+4]), 32'd0);
        check("blank_de",  32'(o_de[nb+4]),  32'd0);
        check("hs_at4",    32'(o_hs[nb+4]),  32'd1);
        check("hs_at3",    32'(o_hs[nb+3]),  32'd0);
        check("hs_at5",    32'(o_hs[nb+5]),  32'd0);
        check("vs_at6",    32'(o_vs[nb+6]),  32'd1);
        check("vs_at5",    32'(o_vs[nb+5]),  32'd0);
        check("vs_at7",    32'(o_vs[nb+7]),  32'd0);

        // Streaming sweep x = 0..15, glyph 0xAA alternates fg/bg
        fill_rom(8'hAA);
        ns = cyc;
        for (int i = 0; i < 16; i++) run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 10'(i), 10'd0);
        idle(6);
        for (int i = 0; i < 16; i++) begin
            check("stream_de",  32'(o_de[ns+4+i]),  32'd1);
            check("stream_rgb", 32'(o_rgb[ns+4+i]), (i % 2 == 0) ? 32'hFFFFFF : 32'h000000);
        end

        // Reset mid-sweep for one cycle at K, sweep resumes at x = 7
        nr = cyc;
        for (int i = 0; i < 6; i++) run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 10'(i), 10'd0);
        k = cyc;
        run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 10'd6, 10'd0);
        for (int i = 7; i < 16; i++) run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 10'(i), 10'd0);
        idle(6);
        check("mid_pre_de", 32'(o_de[k]), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            check("mid_de0",  32'(o_de[k+i]),  32'd0);
            check("mid_rgb0", 32'(o_rgb[k+i]), 32'd0);
        end
        check("mid_first_de",  32'(o_de[k+5]),  32'd1);
        check("mid_first_rgb", 32'(o_rgb[k+5]), 32'h000000);
        check("mid_next_rgb",  32'(o_rgb[k+6]), 32'hFFFFFF);
        check("mid_base", 32'(nr + 6), 32'(k));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lcd_text_renderer.md
LCD_TEXT_RENDERER -- requirements
Module: LCD_text_renderer

Interface
REQ-001 SHALL have parameter FG_COLOR, default 24'hFFFFFF, RGB888 colour of set glyph pixels.
REQ-002 SHALL have parameter BG_COLOR, default 24'h000000, RGB888 colour of clear glyph pixels.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clock  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_de  input  1  data enable from LCD timing generator; pixel (in_x,in_y) is visible.
REQ-007 in_hs  input  1  horizontal sync, passed through.
REQ-008 in_vs  input  1  vertical sync, passed through.
REQ-009 in_x  input  10  pixel column, 0..799.
REQ-010 in_y  input  10  pixel row, 0..479.
REQ-011 column  output  7  character-cell column to character generator, registered.
REQ-012 row  output  6  character-cell row to character generator, registered.
REQ-013 character  input  7  character code from generator, combinational from column/row.
REQ-014 font_address  output  10  font ROM address {character, glyph line}, registered.
REQ-015 font_data  input  8  font ROM line, synchronous ROM, valid one cycle after font_address; bit 7 = leftmost pixel.
REQ-016 out_de, out_hs, out_vs  output  1 each  delayed in_de/in_hs/in_vs.
REQ-017 out_rgb  output  24  rendered pixel colour, registered.

Function
REQ-018 SHALL use 8x8 character cells: column = in_x[9:3], row = in_y[8:3] (in_y[9] ignored), registered at end of cycle N, valid during N+1.
REQ-019 SHALL sample character at end of N+1 and register font_address = {character, y_sub} where y_sub = in_y[2:0] of the cycle-N pixel; valid during N+2.
REQ-020 SHALL consume font_data during N+3 (one-cycle ROM latency) and register out_rgb at end of N+3; total latency in->out = 4 cycles.
REQ-021 SHALL carry x_sub = in_x[2:0], de, hs, vs through a 4-stage shift pipeline aligned with the data path; out_de/out_hs/out_vs equal the cycle-N inputs during N+4.
REQ-022 out_rgb SHALL be FG_COLOR when font_data[7 - x_sub] = 1, else BG_COLOR, when the delayed de = 1.
REQ-023 out_rgb SHALL be 24'h000000 when the delayed de = 0, regardless of font_data.
REQ-024 SHALL accept one pixel per clock with no stall, bubble or handshake; every input cycle produces exactly one output cycle 4 cycles later.
REQ-025 column/row/font_address SHALL update every cycle regardless of in_de (blanking addresses are don't-care but deterministic).
REQ-026 Column arithmetic: in_x 0..799 SHALL map to column 0..99; no wrap or clamp logic required.

Reset
REQ-027 While reset = 1 at a rising edge, all pipeline registers SHALL clear: column=0, row=0, font_address=0, out_de=0, out_hs=0, out_vs=0, out_rgb=0, delayed x_sub/y_sub/de/hs/vs=0.
REQ-028 Reset mid-frame SHALL discard all in-flight pixels; no pre-reset pixel appears at outputs after reset deasserts.
REQ-029 First valid output after reset release SHALL appear 4 cycles after the first post-release input cycle; outputs between are de=0, rgb=0.

Verification
REQ-030 Reset: reset=1 for 2 cycles with in_de=1, in_hs=1 -> all outputs 0 from the cycle after first reset edge.
REQ-031 Latency: in_x=0, in_y=0, in_de=1 at cycle N, ROM model returns 8'h80 -> out_de=1, out_rgb=24'hFFFFFF during N+4.
REQ-032 Addressing: in_x=13, in_y=21 at N -> column=1, row=2 during N+1; character=7'h41 -> font_address=10'h20D during N+2; output reflects font_data bit 2.
REQ-033 Blanking: in_de=0, ROM returns 8'hFF -> out_rgb=24'h000000, out_de=0 four cycles later; in_hs/in_vs pulses appear on out_hs/out_vs exactly 4 cycles delayed.
REQ-034 Streaming: in_x sweeps 0..15 on consecutive cycles, in_de=1, ROM always 8'hAA -> out_rgb alternates FFFFFF,000000 for 16 consecutive cycles, no gaps.
REQ-035 Reset mid-stream: reset at cycle K during sweep -> outputs 0 from K+1; after release no stale pixels, first rendered pixel 4 cycles after first post-release input.
